// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: full-speed USB transmit serialiser.
// SYNC, PID, payload, CRC16 with bit stuffing, NRZI and EOP.
module usb_tx_encoder #(
   parameter int CLKS_PER_BIT = 4,
   parameter int MAX_PACKET   = 64
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [2:0] tx_packet,
   input  logic [6:0] buffer_occupancy,
   input  logic [7:0] tx_packet_data,
   output logic       get_tx_packet_data,
   output logic       dp_out,
   output logic       dm_out,
   output logic       tx_transfer_active,
   output logic       tx_error
);
   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [6:0] MAX_LEN = 7'(MAX_PACKET);

   typedef enum logic [2:0] {
      S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC, S_EOP_SE0, S_EOP_J
   } state_t;

   state_t        r_state;
   logic [TW-1:0] r_tick;
   logic [3:0]    r_bitcnt;
   logic [15:0]   r_shift;
   logic [15:0]   r_crc;
   logic [2:0]    r_ones;
   logic [6:0]    r_left;
   logic [2:0]    r_cmd;
   logic          r_j;
   logic          r_dp;
   logic          r_dm;
   logic          r_active;
   logic          r_err;

   logic          w_isdata;
   logic          w_wrap;
   logic          w_last;
   logic          w_stuff;
   logic          w_fetch;
   logic          w_nbit;
   logic          w_nlvl;
   logic [7:0]    w_pid;
   logic [15:0]   w_crc_out;
   logic [15:0]   w_crc_nxt;

   // PID byte for the latched command
   always_comb begin
      w_pid = 8'h00;
      unique case (r_cmd)
         3'd1:    w_pid = 8'hC3;
         3'd2:    w_pid = 8'h4B;
         3'd3:    w_pid = 8'hD2;
         3'd4:    w_pid = 8'h5A;
         3'd5:    w_pid = 8'h1E;
         default: w_pid = 8'h00;
      endcase
   end

   // Bit-boundary decisions: stuff, byte fetch, next bit and its CRC/NRZI effect
   always_comb begin
      w_crc_out = '0;
      w_nbit    = 1'b0;
      w_isdata  = (r_cmd == 3'd1) || (r_cmd == 3'd2);
      w_wrap    = (r_state != S_IDLE) && (r_tick == TICK_LAST);
      w_last    = (r_state == S_CRC) ? (r_bitcnt == 4'd15)
                                     : (r_bitcnt == 4'd7);
      w_stuff   = w_wrap && (r_ones == 3'd6) &&
                  (r_state inside {S_PID, S_DATA, S_CRC});
      w_fetch   = w_wrap && !w_stuff && w_last && (r_left != 7'd0) &&
                  ((r_state == S_PID && w_isdata) || r_state == S_DATA);
      // complemented CRC, reversed so it leaves bit 15 first
      for (int i = 0; i < 16; i++) w_crc_out[i] = ~r_crc[15-i];
      if (!w_last)                 w_nbit = r_shift[0];
      else if (r_state == S_SYNC)  w_nbit = w_pid[0];
      else if (w_fetch)            w_nbit = tx_packet_data[0];
      else                         w_nbit = w_crc_out[0];
      w_crc_nxt = {r_crc[14:0], 1'b0} ^
                  ((w_nbit ^ r_crc[15]) ? 16'h8005 : 16'h0000);
      w_nlvl    = w_nbit ? r_j : ~r_j;
   end

   // Transmit FSM, bit timer, shifter, CRC and registered line drive
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state  <= S_IDLE;
         r_tick   <= '0;
         r_bitcnt <= '0;
         r_shift  <= '0;
         r_crc    <= '0;
         r_ones   <= '0;
         r_left   <= '0;
         r_cmd    <= '0;
         r_j      <= 1'b1;
         r_dp     <= 1'b1;
         r_dm     <= 1'b0;
         r_active <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_err <= 1'b0;
         if (r_state == S_IDLE) begin
            r_tick <= '0;
            if (tx_packet[2:1] == 2'b11 ||
                ((tx_packet == 3'd1 || tx_packet == 3'd2) &&
                 buffer_occupancy > MAX_LEN)) begin
               r_err <= 1'b1;
            end else if (tx_packet != 3'd0) begin
               r_state  <= S_SYNC;
               r_cmd    <= tx_packet;
               r_left   <= (tx_packet == 3'd1 || tx_packet == 3'd2)
                           ? buffer_occupancy : 7'd0;
               r_crc    <= 16'hFFFF;
               r_ones   <= '0;
               r_bitcnt <= '0;
               r_shift  <= 16'h0040;
               r_j      <= 1'b0;
               r_dp     <= 1'b0;
               r_dm     <= 1'b1;
               r_active <= 1'b1;
            end
         end else begin
            r_tick <= w_wrap ? '0 : r_tick + TW'(1);
            if (w_stuff) begin
               r_ones <= '0;
               r_j    <= ~r_j;
               r_dp   <= ~r_j;
               r_dm   <= r_j;
            end else if (w_wrap) begin
               if ((r_state inside {S_SYNC, S_PID, S_DATA, S_CRC}) &&
                   !w_last) begin
                  r_bitcnt <= r_bitcnt + 4'd1;
                  r_shift  <= r_shift >> 1;
                  r_j      <= w_nlvl;
                  r_dp     <= w_nlvl;
                  r_dm     <= ~w_nlvl;
                  if (r_state != S_SYNC)
                     r_ones <= w_nbit ? r_ones + 3'd1 : 3'd0;
                  if (r_state == S_DATA)
                     r_crc <= w_crc_nxt;
               end else begin
                  unique case (r_state)
                     S_SYNC: begin
                        r_state  <= S_PID;
                        r_bitcnt <= '0;
                        r_shift  <= {9'd0, w_pid[7:1]};
                        r_j      <= w_nlvl;
                        r_dp     <= w_nlvl;
                        r_dm     <= ~w_nlvl;
                        r_ones   <= w_nbit ? 3'd1 : 3'd0;
                     end
                     S_PID, S_DATA: begin
                        r_bitcnt <= '0;
                        if (w_fetch) begin
                           r_state <= S_DATA;
                           r_shift <= {9'd0, tx_packet_data[7:1]};
                           r_left  <= r_left - 7'd1;
                           r_crc   <= w_crc_nxt;
                        end else if (r_state == S_DATA || w_isdata) begin
                           r_state <= S_CRC;
                           r_shift <= {1'b0, w_crc_out[15:1]};
                        end else begin
                           r_state <= S_EOP_SE0;
                        end
                        if (w_fetch || r_state == S_DATA || w_isdata) begin
                           r_j    <= w_nlvl;
                           r_dp   <= w_nlvl;
                           r_dm   <= ~w_nlvl;
                           r_ones <= w_nbit ? r_ones + 3'd1 : 3'd0;
                        end else begin
                           r_ones <= '0;
                           r_dp   <= 1'b0;
                           r_dm   <= 1'b0;
                        end
                     end
                     S_CRC: begin
                        r_state  <= S_EOP_SE0;
                        r_bitcnt <= '0;
                        r_ones   <= '0;
                        r_dp     <= 1'b0;
                        r_dm     <= 1'b0;
                     end
                     S_EOP_SE0: begin
                        if (r_bitcnt == 4'd0) begin
                           r_bitcnt <= 4'd1;
                        end else begin
                           r_state  <= S_EOP_J;
                           r_bitcnt <= '0;
                           r_j      <= 1'b1;
                           r_dp     <= 1'b1;
                           r_dm     <= 1'b0;
                        end
                     end
                     S_EOP_J: begin
                        r_state  <= S_IDLE;
                        r_active <= 1'b0;
                     end
                     default: ;
                  endcase
               end
            end
         end
      end
   end

   assign get_tx_packet_data = w_fetch;
   assign dp_out             = r_dp;
   assign dm_out             = r_dm;
   assign tx_transfer_active = r_active;
   assign tx_error           = r_err;
endmodule

// File: tb/tb_usb_tx_encoder.sv
// tb_usb_tx_encoder: directed bench for the USB transmit encoder.
// Decodes NRZI, removes stuffing and compares against hand/reference data.
module tb_usb_tx_encoder;
   localparam int CPB = 4;
   localparam logic [1:0] J = 2'b10;
   localparam logic [1:0] K = 2'b01;
   localparam logic [1:0] SE0 = 2'b00;
   localparam logic [1:0] ACK_SYMS [19] = '{
      K, J, K, J, K, J, K, K,
      J, J, K, J, J, K, K, K,
      SE0, SE0, J
   };

   logic       clk = 1'b0;
   logic       n_rst = 1'b1;
   logic [2:0] tx_packet = 3'd0;
   logic [6:0] buffer_occupancy = 7'd0;
   logic [7:0] tx_packet_data;
   logic       get_tx_packet_data;
   logic       dp_out;
   logic       dm_out;
   logic       tx_transfer_active;
   logic       tx_error;

   logic [7:0] mem [256];
   logic [7:0] rdptr = 8'd0;
   int nvec = 0;
   int nerr = 0;

   logic [1:0] sym [$];
   int         get_at [$];
   int         nact;
   bit         tmo;
   bit         raw_q [$];
   bit         dst_q [$];
   bit         exp_q [$];
   logic [7:0] pay [$];
   int         nstuff;
   int         stuff_bad;
   int         n_se0;
   bit         tail_j;

   usb_tx_encoder #(.CLKS_PER_BIT(CPB), .MAX_PACKET(64)) dut (
      .clk(clk),
      .n_rst(n_rst),
      .tx_packet(tx_packet),
      .buffer_occupancy(buffer_occupancy),
      .tx_packet_data(tx_packet_data),
      .get_tx_packet_data(get_tx_packet_data),
      .dp_out(dp_out),
      .dm_out(dm_out),
      .tx_transfer_active(tx_transfer_active),
      .tx_error(tx_error)
   );

   always #5 clk = ~clk;

   assign tx_packet_data = mem[rdptr];

   always @(posedge clk) if (get_tx_packet_data) rdptr <= rdptr + 8'd1;

   task automatic load_pay();
      for (int i = 0; i < pay.size(); i++) mem[8'(rdptr + 8'(i))] = pay[i];
   endtask

   task automatic run_pkt(input logic [2:0] cmd, input logic [6:0] occ,
                          input int inj, input logic [2:0] icmd);
      sym.delete();
      get_at.delete();
      nact = 0;
      tmo = 1'b1;
      tx_packet = cmd;
      buffer_occupancy = occ;
      @(posedge clk); #1;
      tx_packet = 3'd0;
      for (int k = 0; k < 3000; k++) begin
         if (!tx_transfer_active) begin
            tmo = 1'b0;
            break;
         end
         nact++;
         if (k % CPB == 0) sym.push_back({dp_out, dm_out});
         if (get_tx_packet_data) get_at.push_back(k);
         if (k == inj) tx_packet = icmd;
         else if (k == inj + 1) tx_packet = 3'd0;
         @(posedge clk); #1;
      end
      nvec++;
      if (tmo) begin
         nerr++;
         $display("FAIL timeout: cmd %0d still active after 3000 clk", cmd);
      end
   endtask

   task automatic decode();
      logic [1:0] prev;
      int i;
      int ones;
      raw_q.delete();
      dst_q.delete();
      nstuff = 0;
      stuff_bad = 0;
      n_se0 = 0;
      tail_j = 1'b0;
      prev = J;
      i = 0;
      while (i < sym.size() && sym[i] != SE0) begin
         raw_q.push_back(sym[i] == prev);
         prev = sym[i];
         i++;
      end
      while (i < sym.size() && sym[i] == SE0) begin
         n_se0++;
         i++;
      end
      if (i == sym.size() - 1) tail_j = (sym[i] == J);
      ones = 0;
      for (int b = 8; b < raw_q.size(); b++) begin
         if (ones == 6) begin
            nstuff++;
            if (raw_q[b]) stuff_bad++;
            ones = 0;
         end else begin
            dst_q.push_back(raw_q[b]);
            ones = raw_q[b] ? ones + 1 : 0;
         end
      end
   endtask

   task automatic build_exp(input logic [7:0] pid, input bit is_data);
      logic [15:0] c;
      logic [7:0] d;
      bit fb;
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back(pid[i]);
      c = 16'hFFFF;
      for (int n = 0; n < pay.size(); n++) begin
         d = pay[n];
         for (int i = 0; i < 8; i++) begin
            exp_q.push_back(d[i]);
            fb = d[i] ^ c[15];
            c = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
         end
      end
      if (is_data) for (int i = 15; i >= 0; i--) exp_q.push_back(~c[i]);
   endtask

   function automatic int qdiff();
      int d = 0;
      if (dst_q.size() != exp_q.size()) d++;
      for (int i = 0; i < dst_q.size() && i < exp_q.size(); i++)
         if (dst_q[i] != exp_q[i]) d++;
      return d;
   endfunction

   function automatic int ack_diff();
      int d = 0;
      if (sym.size() != 19) d++;
      for (int i = 0; i < 19 && i < sym.size(); i++)
         if (sym[i] !== ACK_SYMS[i]) d++;
      return d;
   endfunction

   function automatic logic [7:0] sync_bits();
      logic [7:0] s = 8'h00;
      for (int i = 0; i < 8 && i < raw_q.size(); i++) s[i] = raw_q[i];
      return s;
   endfunction

   task automatic test_reset();
      #1 n_rst = 1'b0;
      #1;
      nvec++;
      if ({dp_out, dm_out, tx_transfer_active, get_tx_packet_data, tx_error}
          !== 5'b10000) begin
         nerr++;
         $display("FAIL reset_async: got %b want 10000",
                  {dp_out, dm_out, tx_transfer_active,
                   get_tx_packet_data, tx_error});
      end
      @(posedge clk); #1;
      n_rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      nvec++;
      if ({dp_out, dm_out, tx_transfer_active, get_tx_packet_data, tx_error}
          !== 5'b10000) begin
         nerr++;
         $display("FAIL reset_idle: got %b want 10000",
                  {dp_out, dm_out, tx_transfer_active,
                   get_tx_packet_data, tx_error});
      end
   endtask

   task automatic test_ack();
      run_pkt(3'd3, 7'd0, -10, 3'd0);
      nvec++;
      if (ack_diff() != 0) begin
         nerr++;
         $display("FAIL ack_line: %0d symbol errors (n=%0d) want 0 (n=19)",
                  ack_diff(), sym.size());
      end
      nvec++;
      if (nact != 76 || get_at.size() != 0) begin
         nerr++;
         $display("FAIL ack_len: active %0d gets %0d want 76 / 0",
                  nact, get_at.size());
      end
   endtask

   task automatic test_zero_len();
      pay.delete();
      run_pkt(3'd1, 7'd0, -10, 3'd0);
      decode();
      build_exp(8'hC3, 1'b1);
      nvec++;
      if (sync_bits() !== 8'h80 || qdiff() != 0) begin
         nerr++;
         $display("FAIL zlen_bits: sync %h diffs %0d want 80 / 0",
                  sync_bits(), qdiff());
      end
      nvec++;
      if (nact != 140 || get_at.size() != 0 || n_se0 != 2 || !tail_j) begin
         nerr++;
         $display("FAIL zlen_frame: act %0d gets %0d se0 %0d j %0d want 140 0 2 1",
                  nact, get_at.size(), n_se0, tail_j);
      end
   endtask

   task automatic test_data1_four();
      int gaps;
      pay = '{8'h00, 8'h01, 8'h02, 8'h03};
      load_pay();
      run_pkt(3'd2, 7'd4, -10, 3'd0);
      decode();
      build_exp(8'h4B, 1'b1);
      gaps = 0;
      for (int i = 1; i < get_at.size(); i++)
         if (get_at[i] - get_at[i-1] != 8 * CPB) gaps++;
      nvec++;
      if (get_at.size() != 4 || gaps != 0) begin
         nerr++;
         $display("FAIL d1_gets: count %0d bad_gaps %0d want 4 / 0",
                  get_at.size(), gaps);
      end
      nvec++;
      if (qdiff() != 0 || stuff_bad != 0 || n_se0 != 2) begin
         nerr++;
         $display("FAIL d1_stream: diffs %0d badstuff %0d se0 %0d want 0 0 2",
                  qdiff(), stuff_bad, n_se0);
      end
   endtask

   task automatic test_stuffing();
      pay = '{8'hFF};
      load_pay();
      run_pkt(3'd1, 7'd1, -10, 3'd0);
      decode();
      build_exp(8'hC3, 1'b1);
      nvec++;
      if (raw_q.size() < 21 || raw_q[20] != 1'b0 || nstuff < 1) begin
         nerr++;
         $display("FAIL ff_stuff: raw[20] %0d nstuff %0d want 0 / >=1",
                  raw_q.size() > 20 ? raw_q[20] : 1'b1, nstuff);
      end
      nvec++;
      if (qdiff() != 0 || stuff_bad != 0 || get_at.size() != 1) begin
         nerr++;
         $display("FAIL ff_stream: diffs %0d badstuff %0d gets %0d want 0 0 1",
                  qdiff(), stuff_bad, get_at.size());
      end
   endtask

   task automatic test_max_len();
      pay.delete();
      for (int i = 0; i < 64; i++) pay.push_back(8'(i * 37 + 5));
      load_pay();
      run_pkt(3'd1, 7'd64, -10, 3'd0);
      decode();
      build_exp(8'hC3, 1'b1);
      nvec++;
      if (get_at.size() != 64 || qdiff() != 0 || stuff_bad != 0) begin
         nerr++;
         $display("FAIL max_len: gets %0d diffs %0d badstuff %0d want 64 0 0",
                  get_at.size(), qdiff(), stuff_bad);
      end
   endtask

   task automatic test_reject();
      logic [2:0] codes [3];
      logic [6:0] occs [3];
      codes = '{3'd1, 3'd6, 3'd7};
      occs  = '{7'd65, 7'd0, 7'd3};
      for (int c = 0; c < 3; c++) begin
         int errs;
         int bad;
         logic [7:0] p0;
         p0 = rdptr;
         errs = 0;
         bad = 0;
         tx_packet = codes[c];
         buffer_occupancy = occs[c];
         @(posedge clk); #1;
         tx_packet = 3'd0;
         for (int k = 0; k < 12; k++) begin
            if (tx_error) errs++;
            if (!dp_out || dm_out || tx_transfer_active || get_tx_packet_data)
               bad++;
            @(posedge clk); #1;
         end
         nvec++;
         if (errs != 1 || bad != 0 || rdptr != p0) begin
            nerr++;
            $display("FAIL reject_%0d: err_cycles %0d busy %0d ptr_moved %0d want 1 0 0",
                     codes[c], errs, bad, rdptr != p0);
         end
      end
   endtask

   task automatic test_ignore_mid();
      run_pkt(3'd3, 7'd5, 20, 3'd1);
      nvec++;
      if (ack_diff() != 0 || nact != 76 || get_at.size() != 0) begin
         nerr++;
         $display("FAIL ignore_mid: symerr %0d act %0d gets %0d want 0 76 0",
                  ack_diff(), nact, get_at.size());
      end
   endtask

   task automatic test_back_to_back();
      pay.delete();
      run_pkt(3'd4, 7'd0, -10, 3'd0);
      decode();
      build_exp(8'h5A, 1'b0);
      nvec++;
      if (qdiff() != 0 || nact != 76) begin
         nerr++;
         $display("FAIL b2b_nak: diffs %0d act %0d want 0 76", qdiff(), nact);
      end
      run_pkt(3'd5, 7'd0, -10, 3'd0);
      decode();
      build_exp(8'h1E, 1'b0);
      nvec++;
      if (qdiff() != 0 || nact != 76 || sync_bits() !== 8'h80) begin
         nerr++;
         $display("FAIL b2b_stall: diffs %0d act %0d sync %h want 0 76 80",
                  qdiff(), nact, sync_bits());
      end
   endtask

   task automatic test_reset_mid();
      int gets;
      logic [7:0] p0;
      pay.delete();
      for (int i = 0; i < 10; i++) pay.push_back(8'(8'hA0 + i));
      load_pay();
      tx_packet = 3'd1;
      buffer_occupancy = 7'd10;
      @(posedge clk); #1;
      tx_packet = 3'd0;
      repeat (100) @(posedge clk);
      #1;
      p0 = rdptr;
      n_rst = 1'b0;
      #1;
      nvec++;
      if ({dp_out, dm_out, tx_transfer_active, get_tx_packet_data} !== 4'b1000)
      begin
         nerr++;
         $display("FAIL rst_mid_async: got %b want 1000",
                  {dp_out, dm_out, tx_transfer_active, get_tx_packet_data});
      end
      gets = 0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (get_tx_packet_data) gets++;
      end
      nvec++;
      if (gets != 0 || rdptr != p0) begin
         nerr++;
         $display("FAIL rst_mid_hold: gets %0d ptr_moved %0d want 0 0",
                  gets, rdptr != p0);
      end
      n_rst = 1'b1;
      @(posedge clk); #1;
      run_pkt(3'd3, 7'd0, -10, 3'd0);
      nvec++;
      if (ack_diff() != 0 || nact != 76 || get_at.size() != 0) begin
         nerr++;
         $display("FAIL rst_mid_ack: symerr %0d act %0d gets %0d want 0 76 0",
                  ack_diff(), nact, get_at.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      test_reset();
      test_ack();
      test_zero_len();
      test_data1_four();
      test_stuffing();
      test_max_len();
      test_reject();
      test_ignore_mid();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
